score_ascii_formatter: RTL and testbench
========================================

# score_ascii_formatter

Sequential binary-to-ASCII formatter for on-screen numeric text (score, lives, level, debug values). It accepts a `DATA_W`-bit unsigned value and produces `DIGITS` ASCII characters in either hexadecimal or true decimal. Decimal conversion uses a serial double-dabble engine. The block sits between game-state registers and the text/sprite renderer, and its results are held stable until the next conversion.

## Interface
- `DATA_W`, default 16: width of the input value, 4..32.
- `DIGITS`, default 5: number of output characters, 1..10.
- `BLANK_LZ`, default 1: 1 = leading zeros are shown as space (0x20); digit 0 is never blanked.

- `Clk` in 1: single clock for all logic.
- `Reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: conversion request, sampled only in IDLE.
- `mode` in 1: 0 = hexadecimal, 1 = decimal; sampled together with `start`.
- `value` in `DATA_W`: unsigned operand; sampled together with `start`.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse when `chars` and `overflow` update.
- `overflow` out 1: the value does not fit in `DIGITS` characters; held until the next `done`.
- `chars` out `DIGITS*8`: ASCII characters. Digit i occupies bits [8i+7:8i]; digit 0 is the least significant.

## Operation
- FSM states: IDLE, SHIFT, ENCODE.
- IDLE, on `start`=1:
  - Latch `value` and `mode`.
  - Clear the BCD register (`DIGITS`×4 bits).
  - Go to SHIFT if `mode`=1, otherwise go to ENCODE.
  - Set `busy`=1.
- SHIFT (decimal only), `DATA_W` cycles, one per input bit, MSB first:
  - Add 3 to every BCD nibble ≥5.
  - Then shift the whole {BCD, operand} left by 1.
  - A 1 shifted out of the top BCD nibble sets the sticky overflow flag.
  - After the `DATA_W`-th shift, go to ENCODE.
- ENCODE, one cycle:
  - Hex mode: nibble i = `value`[4i+3:4i], with zero beyond `DATA_W`. Overflow = any latched bit at or above position 4×`DIGITS` is nonzero.
  - Decimal mode: nibble i = BCD digit i.
  - Mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46 (uppercase).
  - If overflow: every character = 0x2D ('-').
  - Else if `BLANK_LZ`: every zero digit above the most significant nonzero digit becomes 0x20. Digit 0 always shows.
  - Register `chars` and `overflow`, pulse `done`, clear `busy`, and return to IDLE.
- `start` while `busy`=1 is ignored; there is no queueing.
- `start` in the cycle where `done`=1 is accepted, because the FSM is already in IDLE.
- `value` and `mode` may change freely after the sampling edge.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `overflow`=0.
  - `chars`: digit 0 = 0x30; all other digits = 0x20 if `BLANK_LZ`, else 0x30.
  - FSM = IDLE.
- Start sampled at edge k:
  - `busy`=1 from edge k.
  - Hex: `done`=1 after edge k+1 (latency 1).
  - Decimal: `done`=1 after edge k+`DATA_W`+1 (latency `DATA_W`+1; 17 for the defaults).
- `busy` falls on the same edge that raises `done`.
- `chars` and `overflow` change only on the edge that raises `done`.
- `Reset_n` asserted mid-conversion:
  - Immediately (asynchronously) returns all outputs to their reset values.
  - No `done` is produced, and the partial result is discarded.

## Structure
- Package `breakout_text_pkg`:
  - ASCII constants: `ASCII_ZERO`=0x30, `ASCII_A`=0x41, `ASCII_SPACE`=0x20, `ASCII_DASH`=0x2D.
  - FSM state enum `fmt_state_t` {IDLE, SHIFT, ENCODE}.
- Sub-module `ascii_hex_digit`: combinational 4-bit → 8-bit ASCII mapping, instantiated `DIGITS` times in a generate loop.
- Shift counter width is $clog2(`DATA_W`+1).

## Test plan
1. `DATA_W`=16, `DIGITS`=5: `mode`=1, `value`=12345 → `chars`="12345" (0x31 0x32 0x33 0x34 0x35, MS char first); `done` 17 cycles after start; `overflow`=0.
2. `mode`=1, `value`=0, `BLANK_LZ`=1 → "    0". Repeat with `BLANK_LZ`=0 → "00000".
3. `mode`=0, `value`=0xBEEF → " BEEF" with digit 4 = 0x20; `done` 1 cycle after start. Then `mode`=1, `value`=65535 → "65535".
4. `DIGITS`=4: `mode`=1, `value`=10000 → `overflow`=1, `chars`="----". `DIGITS`=3, `mode`=0, `value`=0x1000 → `overflow`=1.
5. Pulse `start` 5 cycles into a decimal conversion → ignored; the original result is returned. Assert `start` in the `done` cycle → second conversion begins and completes correctly.
6. Drive `Reset_n` low at cycle 8 of a decimal conversion → `busy`=0 immediately; `chars` at reset value; no `done` pulse. A new start after release converts normally.

Source files
------------

// File: rtl/breakout_text_pkg.sv
// Shared constants and types for the on-screen text path.
package breakout_text_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } fmt_state_t;

endpackage

// File: rtl/score_ascii_formatter_if.sv
// Request/result bundle between game-state logic and the ASCII formatter.
interface score_ascii_formatter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIGITS = 5
) ();

    logic                  start;
    logic                  mode;
    logic [DATA_W-1:0]     value;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [DIGITS*8-1:0]   chars;

    modport master (
        output start, mode, value,
        input  busy, done, overflow, chars
    );

    modport slave (
        input  start, mode, value,
        output busy, done, overflow, chars
    );

endinterface

// File: rtl/ascii_hex_digit.sv
// One hex nibble to its uppercase ASCII character.
module ascii_hex_digit
    import breakout_text_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'b0000, nibble};
        end else begin
            ascii = ASCII_A + {4'b0000, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/score_ascii_formatter.sv
// Binary to ASCII text formatter: hex in one cycle, decimal via serial double-dabble.
// Results stay registered until the next conversion completes.
module score_ascii_formatter
    import breakout_text_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DIGITS   = 5,
    parameter bit          BLANK_LZ = 1'b1
) (
    input logic                    Clk,
    input logic                    Reset_n,
    score_ascii_formatter_if.slave bus
);

    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned EXT_W = DATA_W + BCD_W;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    function automatic logic [DIGITS*8-1:0] reset_chars();
        logic [DIGITS*8-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[8*i +: 8] = (i == 0 || !BLANK_LZ) ? ASCII_ZERO : ASCII_SPACE;
        end
        return r;
    endfunction

    localparam logic [DIGITS*8-1:0] CHARS_RST = reset_chars();

    fmt_state_t          state_q;
    logic [DATA_W-1:0]   val_q;
    logic                mode_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sticky_q;
    logic                busy_q;
    logic                done_q;
    logic                ovf_q;
    logic [DIGITS*8-1:0] chars_q;

    logic [BCD_W-1:0]    bcd_adj;
    logic [EXT_W-1:0]    hex_ext;
    logic                hex_ovf;
    logic                enc_ovf;
    logic                seen_nz;
    logic [DIGITS*8-1:0] enc_chars;
    logic [3:0]          nib [DIGITS];
    logic [7:0]          asc [DIGITS];

    // Double-dabble correction applied before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Zero-extend so nibbles past DATA_W read as 0 and anything above the display is overflow.
    always_comb begin
        hex_ext = {{BCD_W{1'b0}}, val_q};
        hex_ovf = |(hex_ext >> BCD_W);
        enc_ovf = mode_q ? sticky_q : hex_ovf;
        for (int i = 0; i < DIGITS; i++) begin
            nib[i] = mode_q ? bcd_q[4*i +: 4] : hex_ext[4*i +: 4];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        ascii_hex_digit u_digit (
            .nibble (nib[g]),
            .ascii  (asc[g])
        );
    end

    // Walk from the most significant digit down; blank zeros until the first nonzero.
    always_comb begin
        enc_chars = '0;
        seen_nz   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (nib[i] != 4'd0) begin
                seen_nz = 1'b1;
            end
            if (enc_ovf) begin
                enc_chars[8*i +: 8] = ASCII_DASH;
            end else if (BLANK_LZ && !seen_nz && i != 0) begin
                enc_chars[8*i +: 8] = ASCII_SPACE;
            end else begin
                enc_chars[8*i +: 8] = asc[i];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            val_q    <= '0;
            mode_q   <= 1'b0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            chars_q  <= CHARS_RST;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        val_q    <= bus.value;
                        mode_q   <= bus.mode;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                        sticky_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= bus.mode ? SHIFT : ENCODE;
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], val_q[DATA_W-1]};
                    val_q <= val_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (bcd_adj[BCD_W-1]) begin
                        sticky_q <= 1'b1;
                    end
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= ENCODE;
                    end
                end
                ENCODE: begin
                    chars_q <= enc_chars;
                    ovf_q   <= enc_ovf;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.chars    = chars_q;

endmodule

// File: tb/tb_score_ascii_formatter.sv
// Scoreboard bench: four formatter configurations driven with identical requests.
module tb_score_ascii_formatter;

    logic Clk;
    logic Reset_n;
    int   cyc;
    int   n_cmp;
    int   n_err;

    typedef struct packed {
        logic        ovf;
        logic [79:0] chars;
        int          issue;
        int          lat;
    } sb_t;

    sb_t qa[$];
    sb_t qb[$];
    sb_t qc[$];
    sb_t qd[$];

    score_ascii_formatter_if #(.DATA_W(16), .DIGITS(5)) ifa ();
    score_ascii_formatter_if #(.DATA_W(16), .DIGITS(5)) ifb ();
    score_ascii_formatter_if #(.DATA_W(16), .DIGITS(4)) ifc ();
    score_ascii_formatter_if #(.DATA_W(16), .DIGITS(3)) ifd ();

    score_ascii_formatter #(.DATA_W(16), .DIGITS(5), .BLANK_LZ(1'b1)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .bus(ifa));
    score_ascii_formatter #(.DATA_W(16), .DIGITS(5), .BLANK_LZ(1'b0)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .bus(ifb));
    score_ascii_formatter #(.DATA_W(16), .DIGITS(4), .BLANK_LZ(1'b1)) dut_c (
        .Clk(Clk), .Reset_n(Reset_n), .bus(ifc));
    score_ascii_formatter #(.DATA_W(16), .DIGITS(3), .BLANK_LZ(1'b1)) dut_d (
        .Clk(Clk), .Reset_n(Reset_n), .bus(ifd));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic division into base-10/16 digits, then overflow/blanking rules.
    function automatic sb_t model(input logic [15:0] v, input bit m, input int nd, input bit blz);
        sb_t             r;
        longint unsigned x;
        longint unsigned lim;
        longint unsigned base;
        int              dg[10];
        int              top;
        logic [7:0]      c;
        base = m ? 10 : 16;
        lim  = 1;
        for (int i = 0; i < nd; i++) lim = lim * base;
        x       = {48'd0, v};
        r       = '0;
        r.ovf   = (x >= lim);
        r.lat   = m ? 17 : 1;
        r.issue = cyc;
        top     = 0;
        for (int i = 0; i < nd; i++) begin
            dg[i] = int'(x % base);
            x     = x / base;
            if (dg[i] != 0) top = i;
        end
        for (int i = 0; i < nd; i++) begin
            if (r.ovf)                c = 8'h2D;
            else if (blz && i > top)  c = 8'h20;
            else if (dg[i] < 10)      c = 8'h30 + 8'(dg[i]);
            else                      c = 8'h41 + 8'(dg[i] - 10);
            r.chars[8*i +: 8] = c;
        end
        return r;
    endfunction

    task automatic set_inputs(input logic s, input logic m, input logic [15:0] v);
        ifa.start = s; ifa.mode = m; ifa.value = v;
        ifb.start = s; ifb.mode = m; ifb.value = v;
        ifc.start = s; ifc.mode = m; ifc.value = v;
        ifd.start = s; ifd.mode = m; ifd.value = v;
    endtask

    task automatic start_conv(input bit m, input logic [15:0] v, input bit accept);
        set_inputs(1'b1, m, v);
        if (accept) begin
            qa.push_back(model(v, m, 5, 1'b1));
            qb.push_back(model(v, m, 5, 1'b0));
            qc.push_back(model(v, m, 4, 1'b1));
            qd.push_back(model(v, m, 3, 1'b1));
        end
        @(posedge Clk);
        #1;
        // Operands may change freely once sampled.
        set_inputs(1'b0, 1'($urandom), 16'($urandom));
    endtask

    task automatic mon(input int k, input logic ovf, input logic [79:0] ch);
        sb_t   e;
        bit    have;
        string nm;
        have = 1'b0;
        e    = '0;
        case (k)
            0: begin nm = "a"; if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end end
            1: begin nm = "b"; if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end end
            2: begin nm = "c"; if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end end
            default: begin nm = "d"; if (qd.size() > 0) begin e = qd.pop_front(); have = 1'b1; end end
        endcase
        chk({nm, ".done_expected"}, 80'(have), 80'd1);
        if (have) begin
            chk({nm, ".chars"}, ch, e.chars);
            chk({nm, ".overflow"}, 80'(ovf), 80'(e.ovf));
            chk({nm, ".latency"}, 80'(cyc - e.issue - 1), 80'(e.lat));
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n) begin
            if (ifa.done) mon(0, ifa.overflow, 80'(ifa.chars));
            if (ifb.done) mon(1, ifb.overflow, 80'(ifb.chars));
            if (ifc.done) mon(2, ifc.overflow, 80'(ifc.chars));
            if (ifd.done) mon(3, ifd.overflow, 80'(ifd.chars));
        end
    end

    task automatic flush_all();
        qa.delete(); qb.delete(); qc.delete(); qd.delete();
    endtask

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size() + qd.size()) != 0 && n < budget) begin
            @(negedge Clk);
            #2;
            n++;
        end
        chk("drain_pending", 80'(qa.size() + qb.size() + qc.size() + qd.size()), 80'd0);
        flush_all();
    endtask

    task automatic wait_done_a(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!ifa.done && n < budget);
        chk("a.done_seen", 80'(ifa.done), 80'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        set_inputs(1'b0, 1'b0, 16'd0);
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst.a.chars", 80'(ifa.chars), 80'h20202020_30);
        chk("rst.b.chars", 80'(ifb.chars), 80'h30303030_30);
        chk("rst.c.chars", 80'(ifc.chars), 80'h202020_30);
        chk("rst.d.chars", 80'(ifd.chars), 80'h2020_30);
        chk("rst.a.busy", 80'(ifa.busy), 80'd0);
        chk("rst.a.done", 80'(ifa.done), 80'd0);
        chk("rst.a.overflow", 80'(ifa.overflow), 80'd0);
        @(negedge Clk) Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        start_conv(1'b1, 16'd12345, 1'b1);
        chk("a.busy_after_start", 80'(ifa.busy), 80'd1);
        wait_all(40);
        start_conv(1'b1, 16'd0, 1'b1);      wait_all(40);
        start_conv(1'b0, 16'hBEEF, 1'b1);
        chk("a.busy_hex", 80'(ifa.busy), 80'd1);
        wait_all(10);
        start_conv(1'b1, 16'd65535, 1'b1);  wait_all(40);
        start_conv(1'b1, 16'd10000, 1'b1);  wait_all(40);
        start_conv(1'b1, 16'd9999, 1'b1);   wait_all(40);
        start_conv(1'b0, 16'h1000, 1'b1);   wait_all(10);
        start_conv(1'b0, 16'h0FFF, 1'b1);   wait_all(10);
        start_conv(1'b0, 16'h0000, 1'b1);   wait_all(10);
        start_conv(1'b1, 16'd999, 1'b1);    wait_all(40);
        for (int i = 0; i < 6; i++) begin
            start_conv(1'($urandom), 16'($urandom), 1'b1);
            wait_all(40);
        end

        // Start mid-conversion is dropped; start during done is taken.
        start_conv(1'b1, 16'd4321, 1'b1);
        repeat (4) @(posedge Clk);
        #1;
        start_conv(1'b0, 16'h7777, 1'b0);
        wait_done_a(40);
        start_conv(1'b1, 16'd808, 1'b1);
        wait_all(40);

        // Asynchronous reset partway through a decimal conversion.
        start_conv(1'b1, 16'd5555, 1'b1);
        repeat (7) @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        chk("midrst.a.busy", 80'(ifa.busy), 80'd0);
        chk("midrst.a.done", 80'(ifa.done), 80'd0);
        chk("midrst.a.chars", 80'(ifa.chars), 80'h20202020_30);
        chk("midrst.b.chars", 80'(ifb.chars), 80'h30303030_30);
        chk("midrst.a.overflow", 80'(ifa.overflow), 80'd0);
        flush_all();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (25) @(negedge Clk);
        chk("postrst.a.busy", 80'(ifa.busy), 80'd0);
        chk("postrst.a.chars", 80'(ifa.chars), 80'h20202020_30);
        #2;
        start_conv(1'b1, 16'd31415, 1'b1);
        wait_all(40);
        start_conv(1'b0, 16'h00A5, 1'b1);
        wait_all(10);

        repeat (3) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
